// File: rtl/rvfi_seq_pkg.sv
// Shared types and elaboration helpers for the sequence player: controller
// states, per-character decode result, and string length measurement.
package rvfi_seq_pkg;

  localparam int SEQ_CHARS = 512;
  localparam int SEQ_BITS  = SEQ_CHARS * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       all_ones;
    logic [3:0] nibble;
  } char_dec_t;

  // Leading zero bytes are padding, so the length runs up to the highest
  // non-zero byte; zero bytes embedded after it still count.
  function automatic int seq_len(input logic [SEQ_BITS-1:0] seq);
    int len;
    len = 0;
    for (int i = 0; i < SEQ_CHARS; i++) begin
      if (seq[i*8 +: 8] != 8'h00) len = i + 1;
    end
    return len;
  endfunction

  function automatic char_dec_t char_nibble(input logic [7:0] ch);
    char_dec_t r;
    r = '{valid: 1'b1, all_ones: 1'b0, nibble: 4'h0};
    if (ch >= "0" && ch <= "9") begin
      r.nibble = ch[3:0];
    end else if ((ch >= "A" && ch <= "F") || (ch >= "a" && ch <= "f")) begin
      r.nibble = ch[3:0] + 4'd9;
    end else if (ch == "-") begin
      r.all_ones = 1'b1;
    end else if (ch != "_") begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rvfi_seq_field_dec.sv
// Decodes one channel field of D ASCII characters (first character in the
// most significant byte) into a W-bit value and a valid flag.
module rvfi_seq_field_dec
  import rvfi_seq_pkg::*;
#(
  parameter int W = 4,
  parameter int D = 1
) (
  input  logic [D*8-1:0] chars_i,
  output logic [W-1:0]   value_o,
  output logic           valid_o
);

  logic [D*4-1:0] nibbles;
  logic           any_ones;
  logic           all_valid;

  always_comb begin
    char_dec_t cd;
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    nibbles   = '0;
    any_ones  = 1'b0;
    all_valid = 1'b1;
    for (int j = 0; j < D; j++) begin
      cd               = char_nibble(chars_i[j*8 +: 8]);
      nibbles[j*4 +: 4] = cd.nibble;
      any_ones         = any_ones | cd.all_ones;
      all_valid        = all_valid & cd.valid;
    end
  end

  // An invalid character anywhere in the field outranks '-'.
  always_comb begin
    value_o = '0;
    valid_o = all_valid;
    if (all_valid) begin
      value_o = any_ones ? '1 : nibbles[W-1:0];
    end
  end

endmodule

// File: rtl/rvfi_seq_player.sv
// Plays a compile-time string of hex-like steps onto NCH channels, one step
// per advance strobe, with start/busy/done handshake and optional looping.
module rvfi_seq_player
  import rvfi_seq_pkg::*;
#(
  parameter logic [SEQ_BITS-1:0] SEQ  = '0,
  parameter int                  W    = 4,
  parameter int                  NCH  = 1,
  parameter int                  LOOP = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             advance,
  output logic [NCH*W-1:0] dout,
  output logic [NCH-1:0]   en,
  output logic             busy,
  output logic             done,
  output logic [15:0]      step,
  output logic [7:0]       loops
);

  localparam int D      = (W + 3) / 4;
  localparam int L      = NCH * D;
  localparam int SLEN   = seq_len(SEQ);
  localparam int NSTEPS = SLEN / L;
  localparam logic [15:0] LAST_STEP = 16'((NSTEPS > 0) ? NSTEPS - 1 : 0);

  if (W < 1 || W > 16) begin : g_bad_w
    $error("rvfi_seq_player: W must be 1..16");
  end
  if (NCH < 1 || NCH > 4) begin : g_bad_nch
    $error("rvfi_seq_player: NCH must be 1..4");
  end
  if (SLEN % L != 0) begin : g_bad_len
    $error("rvfi_seq_player: SEQ length is not a multiple of the step length");
  end

  state_e      state_q;
  logic [15:0] step_q;
  logic [7:0]  loops_q;
  logic        busy_q;
  logic        done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      loops_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            step_q  <= '0;
            loops_q <= '0;
            if (NSTEPS == 0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= PLAY;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        PLAY: begin
          if (advance) begin
            if (step_q != LAST_STEP) begin
              step_q <= step_q + 16'd1;
            end else if (LOOP != 0) begin
              step_q <= '0;
              if (loops_q != 8'hFF) loops_q <= loops_q + 8'd1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign step  = step_q;
  assign loops = loops_q;

  if (NSTEPS > 0) begin : g_play
    localparam int STEP_BITS = L * 8;

    logic [STEP_BITS-1:0] step_chars;
    logic [W-1:0]         field_val [NCH];
    logic [NCH-1:0]       field_ok;

    // Step 0 sits in the most significant characters of the used region.
    always_comb begin
      step_chars = STEP_BITS'(SEQ >> (32'(LAST_STEP - step_q) * STEP_BITS));
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
      rvfi_seq_field_dec #(
        .W (W),
        .D (D)
      ) u_dec (
        .chars_i (step_chars[(NCH-1-c)*D*8 +: D*8]),
        .value_o (field_val[c]),
        .valid_o (field_ok[c])
      );
    end

    always_comb begin
      dout = '0;
      en   = '0;
      if (state_q == PLAY) begin
        for (int c = 0; c < NCH; c++) begin
          dout[c*W +: W] = field_val[c];
          en[c]          = field_ok[c];
        end
      end
    end
  end else begin : g_empty
    assign dout = '0;
    assign en   = '0;
  end

endmodule

// File: tb/tb_rvfi_seq_player.sv
// Drives five player configurations with shared stimulus and checks every
// output each cycle against a string-level model of the playback rules.
module tb_rvfi_seq_player;

  localparam int NI = 5;

  logic clock = 1'b0;
  logic reset, start, advance;
  always #5 clock = ~clock;

  logic [3:0]  dout_a;  logic [0:0] en_a;  logic busy_a, done_a;  logic [15:0] step_a;  logic [7:0] loops_a;
  logic [15:0] dout_b;  logic [1:0] en_b;  logic busy_b, done_b;  logic [15:0] step_b;  logic [7:0] loops_b;
  logic [3:0]  dout_c;  logic [0:0] en_c;  logic busy_c, done_c;  logic [15:0] step_c;  logic [7:0] loops_c;
  logic [3:0]  dout_d;  logic [0:0] en_d;  logic busy_d, done_d;  logic [15:0] step_d;  logic [7:0] loops_d;
  logic [11:0] dout_e;  logic [3:0] en_e;  logic busy_e, done_e;  logic [15:0] step_e;  logic [7:0] loops_e;

  rvfi_seq_player #(.SEQ(4096'("1a3")), .W(4), .NCH(1), .LOOP(0)) u_a (
    .clock(clock), .reset(reset), .start(start), .advance(advance), .dout(dout_a),
    .en(en_a), .busy(busy_a), .done(done_a), .step(step_a), .loops(loops_a));
  rvfi_seq_player #(.SEQ(4096'("0f-x")), .W(8), .NCH(2), .LOOP(0)) u_b (
    .clock(clock), .reset(reset), .start(start), .advance(advance), .dout(dout_b),
    .en(en_b), .busy(busy_b), .done(done_b), .step(step_b), .loops(loops_b));
  rvfi_seq_player #(.SEQ(4096'("12")), .W(4), .NCH(1), .LOOP(1)) u_c (
    .clock(clock), .reset(reset), .start(start), .advance(advance), .dout(dout_c),
    .en(en_c), .busy(busy_c), .done(done_c), .step(step_c), .loops(loops_c));
  rvfi_seq_player #(.SEQ(4096'(0)), .W(4), .NCH(1), .LOOP(0)) u_d (
    .clock(clock), .reset(reset), .start(start), .advance(advance), .dout(dout_d),
    .en(en_d), .busy(busy_d), .done(done_d), .step(step_d), .loops(loops_d));
  rvfi_seq_player #(.SEQ(4096'("x1-_F9Ab")), .W(3), .NCH(4), .LOOP(1)) u_e (
    .clock(clock), .reset(reset), .start(start), .advance(advance), .dout(dout_e),
    .en(en_e), .busy(busy_e), .done(done_e), .step(step_e), .loops(loops_e));

  logic [63:0] act_dout [NI];
  logic [3:0]  act_en   [NI];
  logic        act_busy [NI];
  logic        act_done [NI];
  logic [15:0] act_step [NI];
  logic [7:0]  act_loops[NI];

  assign act_dout[0] = 64'(dout_a); assign act_en[0] = 4'(en_a);
  assign act_dout[1] = 64'(dout_b); assign act_en[1] = 4'(en_b);
  assign act_dout[2] = 64'(dout_c); assign act_en[2] = 4'(en_c);
  assign act_dout[3] = 64'(dout_d); assign act_en[3] = 4'(en_d);
  assign act_dout[4] = 64'(dout_e); assign act_en[4] = 4'(en_e);
  assign act_busy[0] = busy_a; assign act_done[0] = done_a; assign act_step[0] = step_a; assign act_loops[0] = loops_a;
  assign act_busy[1] = busy_b; assign act_done[1] = done_b; assign act_step[1] = step_b; assign act_loops[1] = loops_b;
  assign act_busy[2] = busy_c; assign act_done[2] = done_c; assign act_step[2] = step_c; assign act_loops[2] = loops_c;
  assign act_busy[3] = busy_d; assign act_done[3] = done_d; assign act_step[3] = step_d; assign act_loops[3] = loops_d;
  assign act_busy[4] = busy_e; assign act_done[4] = done_e; assign act_step[4] = step_e; assign act_loops[4] = loops_e;

  // Model configuration mirrors the instance parameters.
  string m_seq  [NI] = '{"1a3", "0f-x", "12", "", "x1-_F9Ab"};
  int    m_w    [NI] = '{4, 8, 4, 4, 3};
  int    m_nch  [NI] = '{1, 2, 1, 1, 4};
  int    m_loop [NI] = '{0, 0, 1, 0, 1};

  // Model state: mode 0 = idle, 1 = playing, 2 = finished.
  int m_mode [NI] = '{default: 0};
  int m_step [NI] = '{default: 0};
  int m_loops[NI] = '{default: 0};

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nsteps(input int i);
    return m_seq[i].len() / (m_nch[i] * ((m_w[i] + 3) / 4));
  endfunction

  function automatic void exp_field(input int i, input int s, input int c,
                                    output logic [15:0] v, output logic ok);
    string  str;
    byte    ch;
    int     d, base;
    longint acc;
    bit     dash;
    str  = m_seq[i];
    d    = (m_w[i] + 3) / 4;
    base = (s * m_nch[i] + c) * d;
    acc  = 0;
    dash = 0;
    ok   = 1'b1;
    for (int j = 0; j < d; j++) begin
      ch = str[base + j];
      if (ch >= "0" && ch <= "9")      acc = acc * 16 + (ch - "0");
      else if (ch >= "a" && ch <= "f") acc = acc * 16 + (ch - "a" + 10);
      else if (ch >= "A" && ch <= "F") acc = acc * 16 + (ch - "A" + 10);
      else if (ch == "_")              acc = acc * 16;
      else if (ch == "-")              dash = 1;
      else                             ok = 1'b0;
    end
    if (!ok)       v = 16'h0;
    else if (dash) v = 16'((64'd1 << m_w[i]) - 1);
    else           v = 16'(acc & ((64'd1 << m_w[i]) - 1));
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_mode[i] = 0; m_step[i] = 0; m_loops[i] = 0;
      end else if (m_mode[i] != 1) begin
        if (start) begin
          m_mode[i]  = (nsteps(i) == 0) ? 2 : 1;
          m_step[i]  = 0;
          m_loops[i] = 0;
        end
      end else if (advance) begin
        if (m_step[i] < nsteps(i) - 1) m_step[i]++;
        else if (m_loop[i] != 0) begin
          m_step[i] = 0;
          if (m_loops[i] < 255) m_loops[i]++;
        end else m_mode[i] = 2;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < NI; i++) begin
        logic [63:0] e_dout;
        logic [3:0]  e_en;
        logic [15:0] v;
        logic        ok;
        e_dout = '0;
        e_en   = '0;
        if (m_mode[i] == 1) begin
          for (int c = 0; c < m_nch[i]; c++) begin
            exp_field(i, m_step[i], c, v, ok);
            e_dout = e_dout | (64'(v) << (c * m_w[i]));
            e_en[c] = ok;
          end
        end
        check($sformatf("dut%0d.dout", i),  act_dout[i], e_dout);
        check($sformatf("dut%0d.en", i),    64'(act_en[i]), 64'(e_en));
        check($sformatf("dut%0d.busy", i),  64'(act_busy[i]), 64'(m_mode[i] == 1));
        check($sformatf("dut%0d.done", i),  64'(act_done[i]), 64'(m_mode[i] == 2));
        check($sformatf("dut%0d.step", i),  64'(act_step[i]), 64'(m_step[i]));
        check($sformatf("dut%0d.loops", i), 64'(act_loops[i]), 64'(m_loops[i]));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; advance = 1'b0;
    repeat (2) @(negedge clock);
    cmp_en = 1'b1;
    check("rst.busy_a", 64'(busy_a), 64'd0);
    check("rst.done_d", 64'(done_d), 64'd0);
    check("rst.step_c", 64'(step_c), 64'd0);
    check("rst.en_b",   64'(en_b),   64'd0);

    // Start, then advance every cycle.
    reset = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("s0.dout_a", 64'(dout_a), 64'h1);
    check("s0.en_a",   64'(en_a),   64'h1);
    check("s0.dout_b", 64'(dout_b), 64'h000f);
    check("s0.en_b",   64'(en_b),   64'h1);
    check("s0.done_d", 64'(done_d), 64'h1);
    check("s0.busy_d", 64'(busy_d), 64'h0);
    check("s0.dout_e", 64'(dout_e), 64'h1C8);
    check("s0.en_e",   64'(en_e),   64'hE);
    advance = 1'b1;
    @(negedge clock);
    check("s1.dout_a", 64'(dout_a), 64'ha);
    check("s1.step_c", 64'(step_c), 64'd1);
    check("s1.done_b", 64'(done_b), 64'd1);
    check("s1.dout_e", 64'(dout_e), 64'h68F);
    check("s1.en_e",   64'(en_e),   64'hF);
    @(negedge clock);
    check("s2.dout_a",  64'(dout_a),  64'h3);
    check("s2.step_c",  64'(step_c),  64'd0);
    check("s2.loops_c", 64'(loops_c), 64'd1);
    @(negedge clock);
    check("s3.done_a", 64'(done_a), 64'd1);
    check("s3.en_a",   64'(en_a),   64'd0);
    check("s3.busy_a", 64'(busy_a), 64'd0);
    repeat (2) @(negedge clock);
    check("s5.step_c",  64'(step_c),  64'd1);
    check("s5.loops_c", 64'(loops_c), 64'd2);
    check("s5.busy_c",  64'(busy_c),  64'd1);
    check("s5.done_c",  64'(done_c),  64'd0);
    advance = 1'b0;

    // Restart, advance once, then hold with a stray start pulse.
    reset = 1'b1; @(negedge clock);
    reset = 1'b0; start = 1'b1; @(negedge clock);
    start = 1'b0; advance = 1'b1; @(negedge clock);
    advance = 1'b0;
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      @(negedge clock);
      check("hold.step_a", 64'(step_a), 64'd1);
      check("hold.dout_a", 64'(dout_a), 64'ha);
      check("hold.step_c", 64'(step_c), 64'd1);
    end
    start = 1'b0;

    // Reset lands while instance c sits on step 1 with advance high.
    advance = 1'b1;
    repeat (2) @(negedge clock);
    check("pre.loops_c", 64'(loops_c), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid.step_c",  64'(step_c),  64'd0);
    check("mid.loops_c", 64'(loops_c), 64'd0);
    check("mid.busy_c",  64'(busy_c),  64'd0);
    check("mid.en_c",    64'(en_c),    64'd0);
    check("mid.done_a",  64'(done_a),  64'd0);
    reset = 1'b0; advance = 1'b0;

    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      reset   = ($urandom_range(0, 99) < 2);
      start   = ($urandom_range(0, 99) < 6);
      advance = ($urandom_range(0, 99) < 55);
    end
    @(negedge clock);
    reset = 1'b0; start = 1'b0; advance = 1'b0;
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_seq_player.md
Name: rvfi_seq_player

Overview:
Parametrised, multi-channel successor to the per-cycle character-sequence driver used in formal testbenches.
- Plays a compile-time string of hex-like steps onto NCH channels of W bits each.
- Steps advance under an explicit advance strobe rather than a free-running cycle count, with start/busy/done handshake and optional looping.
- Drives or constrains DUT inputs (e.g. instruction, stall or IRQ patterns) inside the formal testbench top.

Parameters:
- SEQ, [4095:0] "": ASCII step string, first character most significant; leading zero bytes are padding.
- W, 4: channel width in bits, 1..16.
- NCH, 1: channel count, 1..4.
- LOOP, 0: 1 = wrap to step 0 after the last step; 0 = stop in DONE.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin playback; accepted in IDLE or DONE
- advance  in  1  move to next step; only acts in PLAY
- dout  out  NCH*W  channel c at bits [c*W +: W]
- en  out  NCH  per-channel valid for the current step
- busy  out  1  high in PLAY
- done  out  1  high in DONE
- step  out  16  current step index
- loops  out  8  completed wraps, saturating at 255

Behaviour:
- Elaboration constants:
  - D = ceil(W/4) characters per field.
  - L = NCH*D characters per step.
  - SLEN = count of characters from the first non-zero byte.
  - NSTEPS = SLEN/L. Elaboration error if SLEN mod L != 0.
- Step layout: channel 0 is the leftmost field. Within a field, the first character is the most significant nibble. The value is truncated to W bits.
- Character decode:
  - 0-9, a-f, A-F give their nibble value.
  - '_' gives 0.
  - '-' gives all-ones for the whole field.
  - 'x', 'X', ' ' or any other character clears en[c]; dout field is 0 in that case.
- State machine (registered):
  - IDLE -> PLAY on start; step=0.
  - PLAY with advance and step < NSTEPS-1: step+1.
  - PLAY with advance and step == NSTEPS-1: if LOOP, step=0 and loops+1 (saturating). Otherwise go to DONE.
  - PLAY with start: ignored.
  - DONE with start: go to PLAY, step=0, loops=0.
  - In IDLE and DONE, advance is ignored.
- Outputs:
  - dout and en are combinational decodes of the registered step, so a step's values are visible in the same cycle step shows it.
  - The first step is visible the cycle after start.
  - en=0 and dout=0 in IDLE and DONE.
- Empty SEQ (NSTEPS=0): start moves IDLE to DONE directly; done=1 the next cycle.
- Reset: state=IDLE, step=0, loops=0, busy=0, done=0, en=0, dout=0. Reset wins over start and advance in the same cycle, including mid-playback.
- done stays high until start or reset.
- busy and done are never high together.

Decomposition:
- Package rvfi_seq_pkg holds:
  - state enum {IDLE, PLAY, DONE};
  - function seq_len(SEQ);
  - function char_nibble(ch) returning {valid, all_ones, nibble[3:0]}.
- One sub-module, rvfi_seq_field_dec #(W, D):
  - decodes D characters into a W-bit value plus valid;
  - instantiated NCH times via generate.

Test Plan:
- SEQ="1a3", W=4, NCH=1, LOOP=0:
  - start, then advance every cycle.
  - dout=1, a, 3 on steps 0, 1, 2; en=1.
  - After the third advance, done=1 and en=0.
- SEQ="0f-x", W=8, NCH=2 (D=2, L=4, single step):
  - After start: ch0=0x0f en=1, then ch1 field "-x".
  - '-' sets ch1 all-ones but 'x' clears it, so en[1]=0 and dout[15:8]=0.
- SEQ="12", W=4, NCH=1, LOOP=1:
  - start, then 5 advances.
  - step sequence 0, 1, 0, 1, 0, 1; loops=2; busy stays 1; done=0.
- Reset mid-playback:
  - Assert reset with step=1 and advance=1.
  - Next cycle: state=IDLE, step=0, en=0, busy=0, loops=0.
- advance held low in PLAY for 10 cycles: step and dout stable. A start pulse during PLAY has no effect.
- SEQ="", start: done=1 the next cycle; busy never rises.
